// File: rtl/mem_map_pkg.sv
// Shared address-map constants for the CPU memory bus responder.
// Holds the I/O window decode, register offsets and status bit positions.
package mem_map_pkg;

  localparam logic [1:0] IO_SEL_BITS = 2'b11;
  localparam logic [2:0] IO_OFF_DATA = 3'd0;
  localparam logic [2:0] IO_OFF_STAT = 3'd4;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_OVERFLOW = 2;

  typedef enum logic [1:0] {
    IO_REG_NONE,
    IO_REG_DATA,
    IO_REG_STAT
  } io_reg_e;

  function automatic io_reg_e decode_io_off(input logic [2:0] off);
    case (off)
      IO_OFF_DATA: return IO_REG_DATA;
      IO_OFF_STAT: return IO_REG_STAT;
      default:     return IO_REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with a combinational head, used for the TX stream.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [7:0]  mem_reg [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_reg[rd_ptr_reg];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: routes CPU byte accesses to block RAM or the I/O window
// (TX FIFO, RX stream, status, program-done) with a uniform one-cycle read latency.
module mem_bus_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [31:0]               cpu_a,
  input  logic [7:0]                cpu_dout,
  input  logic                      cpu_wr,
  output logic [7:0]                cpu_din,
  output logic                      io_buffer_full,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_en,
  output logic                      ram_r_nw,
  output logic [7:0]                ram_d_in,
  input  logic [7:0]                ram_d_out,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      program_done
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          io_sel;
  logic          io_act;
  io_reg_e       io_reg;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_empty;
  logic          tx_full;
  logic [CW-1:0] tx_count;
  logic          io_sel_q;
  logic [7:0]    io_rdata_q;
  logic [7:0]    io_rdata_next;
  logic          overflow_reg;
  logic          program_done_reg;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^cpu_a[31:18];

  assign io_sel = (cpu_a[17:16] == IO_SEL_BITS);
  assign io_act = rdy_in & io_sel;
  assign io_reg = decode_io_off(cpu_a[2:0]);

  assign ram_a    = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign ram_en   = rdy_in & ~io_sel;
  assign ram_r_nw = ~cpu_wr;
  assign ram_d_in = cpu_dout;

  assign tx_push  = io_act & cpu_wr & (io_reg == IO_REG_DATA);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = io_act & ~cpu_wr & (io_reg == IO_REG_DATA) & rx_valid;

  assign io_buffer_full = (tx_count >= CW'(TX_DEPTH - 1));
  assign program_done   = program_done_reg;
  assign cpu_din        = io_sel_q ? io_rdata_q : ram_d_out;

  byte_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (cpu_dout),
    .dout   (tx_data),
    .empty  (tx_empty),
    .full   (tx_full),
    .count  (tx_count)
  );

  always_comb begin
    io_rdata_next = 8'h00;
    if (io_sel && !cpu_wr) begin
      case (io_reg)
        IO_REG_DATA: io_rdata_next = rx_valid ? rx_data : 8'h00;
        IO_REG_STAT: begin
          io_rdata_next[STAT_TX_FULL]  = tx_full;
          io_rdata_next[STAT_RX_VALID] = rx_valid;
          io_rdata_next[STAT_OVERFLOW] = overflow_reg;
        end
        default:     io_rdata_next = 8'h00;
      endcase
    end
  end

  // Read-data path freezes with rdy_in so cpu_din holds during a stall.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      io_sel_q         <= 1'b0;
      io_rdata_q       <= 8'h00;
      overflow_reg     <= 1'b0;
      program_done_reg <= 1'b0;
    end else begin
      if (rdy_in) begin
        io_sel_q   <= io_sel;
        io_rdata_q <= io_rdata_next;
      end
      if (tx_push && tx_full && !tx_pop) begin
        overflow_reg <= 1'b1;
      end
      if (io_act && cpu_wr && io_reg == IO_REG_STAT) begin
        program_done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed scenarios plus a randomized
// run, all checked against a queue/array reference model of the bus behaviour.
module tb_mem_bus_responder;

  localparam int RAW = 17;
  localparam int TX_DEPTH = 8;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic           rdy_in = 1'b0;
  logic [31:0]    cpu_a = '0;
  logic [7:0]     cpu_dout = '0;
  logic           cpu_wr = 1'b0;
  logic [7:0]     cpu_din;
  logic           io_buffer_full;
  logic [RAW-1:0] ram_a;
  logic           ram_en;
  logic           ram_r_nw;
  logic [7:0]     ram_d_in;
  logic [7:0]     ram_d_out = 8'h00;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_valid = 1'b0;
  logic           rx_ready;
  logic           program_done;

  mem_bus_responder #(
    .RAM_ADDR_WIDTH (RAW),
    .TX_DEPTH       (TX_DEPTH)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .ram_a          (ram_a),
    .ram_en         (ram_en),
    .ram_r_nw       (ram_r_nw),
    .ram_d_in       (ram_d_in),
    .ram_d_out      (ram_d_out),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_done   (program_done)
  );

  always #5 clk_in = ~clk_in;

  // Environment RAM: registered read, output holds when not enabled.
  logic [7:0] ram_mem [0:(1<<RAW)-1];
  always @(posedge clk_in) begin
    if (ram_en) begin
      if (!ram_r_nw) ram_mem[ram_a] <= ram_d_in;
      else           ram_d_out <= ram_mem[ram_a];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] ref_mem [int];
  logic [7:0] tx_q [$];
  logic [7:0] sink_q [$];
  bit         m_ovf;
  bit         m_done;
  logic [7:0] exp_din;
  bit         exp_chk;
  bit         exp_rx_ready;
  bit         exp_ram_en;
  logic       obs_rx_ready;
  logic       obs_ram_en;

  function automatic logic [7:0] ref_rd(input int addr);
    if (ref_mem.exists(addr)) return ref_mem[addr];
    return 8'h00;
  endfunction

  // One bus cycle, launched right after a falling edge; returns after the next one.
  task automatic do_cycle(input logic [31:0] a, input logic [7:0] d, input bit wr,
                          input bit rdy, input bit txr);
    bit io;
    bit full_b;
    bit pop;
    logic [2:0] off;
    cpu_a = a; cpu_dout = d; cpu_wr = wr; rdy_in = rdy; tx_ready = txr;
    #1;
    obs_rx_ready = rx_ready;
    obs_ram_en   = ram_en;
    io     = (a[17:16] == 2'b11);
    off    = a[2:0];
    full_b = (tx_q.size() == TX_DEPTH);
    pop    = (tx_q.size() > 0) && txr;
    exp_rx_ready = rdy && io && !wr && off == 3'd0 && rx_valid;
    exp_ram_en   = rdy && !io;
    if (rdy) begin
      exp_chk = !wr;
      if (!wr) begin
        if (!io)               exp_din = ref_rd(int'(a[RAW-1:0]));
        else if (off == 3'd0)  exp_din = rx_valid ? rx_data : 8'h00;
        else if (off == 3'd4)  exp_din = {5'b0, m_ovf, rx_valid, full_b};
        else                   exp_din = 8'h00;
      end
    end
    @(posedge clk_in);
    if (pop) sink_q.push_back(tx_q.pop_front());
    if (rdy && io && wr && off == 3'd0) begin
      if (!full_b || pop) tx_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (rdy && io && wr && off == 3'd4) m_done = 1'b1;
    if (rdy && !io && wr) ref_mem[int'(a[RAW-1:0])] = d;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; cpu_a = 32'h0003_0000; cpu_wr = 1'b1; cpu_dout = 8'hEE;
    tx_ready = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0; rdy_in = 1'b0; cpu_wr = 1'b0;
    tx_q.delete(); sink_q.delete();
    m_ovf = 0; m_done = 0; exp_chk = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (program_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", program_done); end
    n_cmp++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_buf_full got %b want 0", io_buffer_full); end
    n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
    @(negedge clk_in);
    do_cycle(32'h0003_0004, 8'h00, 0, 1, 0);
    n_cmp++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL reset_status got %h want 00", cpu_din); end
    $display("test_reset: done");
  endtask

  task automatic test_ram_roundtrip();
    do_cycle(32'h0000_0010, 8'hA5, 1, 1, 0);
    n_cmp++; if (obs_ram_en !== 1'b1) begin n_err++; $display("FAIL ram_wr_en got %b want 1", obs_ram_en); end
    do_cycle(32'h0000_0010, 8'h00, 0, 1, 0);
    n_cmp++; if (cpu_din !== 8'hA5) begin n_err++; $display("FAIL ram_rd got %h want a5", cpu_din); end
    do_cycle(32'h0003_0001, 8'h00, 0, 1, 0);
    n_cmp++; if (obs_ram_en !== 1'b0) begin n_err++; $display("FAIL ram_en_io got %b want 0", obs_ram_en); end
    $display("test_ram_roundtrip: read %h", cpu_din);
  endtask

  task automatic test_tx_stream();
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    foreach (bytes[i]) do_cycle(32'h0003_0000, bytes[i], 1, 1, 0);
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL tx_valid got %b want 1", tx_valid); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tx_data !== bytes[i]) begin n_err++; $display("FAIL tx_order[%0d] got %h want %h", i, tx_data, bytes[i]); end
      do_cycle(32'h0, 8'h0, 0, 0, 1);
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained got %b want 0", tx_valid); end
    $display("test_tx_stream: sink saw %0d bytes", sink_q.size());
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 9; i++) begin
      do_cycle(32'h0003_0000, 8'(8'h10 + i), 1, 1, 0);
      if (i == 5) begin
        n_cmp++; if (io_buffer_full !== 1'b0) begin n_err++; $display("FAIL full_at6 got %b want 0", io_buffer_full); end
      end
      if (i == 6) begin
        n_cmp++; if (io_buffer_full !== 1'b1) begin n_err++; $display("FAIL full_at7 got %b want 1", io_buffer_full); end
      end
    end
    do_cycle(32'h0003_0004, 8'h00, 0, 1, 0);
    n_cmp++; if (cpu_din !== 8'h05) begin n_err++; $display("FAIL ovf_status got %h want 05", cpu_din); end
    sink_q.delete();
    for (int i = 0; i < TX_DEPTH; i++) begin
      n_cmp++; if (tx_data !== 8'(8'h10 + i)) begin n_err++; $display("FAIL ovf_drain[%0d] got %h want %h", i, tx_data, 8'(8'h10 + i)); end
      do_cycle(32'h0, 8'h0, 0, 0, 1);
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped got %b want 0", tx_valid); end
    $display("test_full_overflow: drained %0d bytes", sink_q.size());
  endtask

  task automatic test_rx_read();
    rx_valid = 1'b1; rx_data = 8'h7E;
    do_cycle(32'h0003_0000, 8'h00, 0, 1, 0);
    rx_valid = 1'b0; rx_data = 8'h00;
    n_cmp++; if (obs_rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_pulse got %b want 1", obs_rx_ready); end
    n_cmp++; if (cpu_din !== 8'h7E) begin n_err++; $display("FAIL rx_data got %h want 7e", cpu_din); end
    do_cycle(32'h0000_0010, 8'h00, 0, 1, 0);
    n_cmp++; if (obs_rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_pulse_end got %b want 0", obs_rx_ready); end
    do_cycle(32'h0003_0000, 8'h00, 0, 1, 0);
    n_cmp++; if (obs_rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_empty_ready got %b want 0", obs_rx_ready); end
    n_cmp++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL rx_empty_data got %h want 00", cpu_din); end
    $display("test_rx_read: done");
  endtask

  task automatic test_stall();
    do_cycle(32'h0000_0123, 8'h3C, 1, 1, 0);
    do_cycle(32'h0000_0123, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      do_cycle((i % 2 == 0) ? 32'h0000_0123 : 32'h0003_0000, 8'hFF, 1, 0, 0);
      n_cmp++; if (cpu_din !== 8'h3C) begin n_err++; $display("FAIL stall_hold[%0d] got %h want 3c", i, cpu_din); end
      n_cmp++; if (obs_ram_en !== 1'b0) begin n_err++; $display("FAIL stall_ram_en[%0d] got %b want 0", i, obs_ram_en); end
      n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL stall_fifo[%0d] got %b want 0", i, tx_valid); end
    end
    do_cycle(32'h0000_0123, 8'h00, 0, 1, 0);
    n_cmp++; if (cpu_din !== 8'h3C) begin n_err++; $display("FAIL stall_ram_kept got %h want 3c", cpu_din); end
    $display("test_stall: done");
  endtask

  task automatic test_reset_mid();
    do_cycle(32'h0003_0004, 8'h01, 1, 1, 0);
    for (int i = 0; i < 3; i++) do_cycle(32'h0003_0000, 8'(8'h60 + i), 1, 1, 0);
    n_cmp++; if (program_done !== 1'b1) begin n_err++; $display("FAIL mid_done_set got %b want 1", program_done); end
    do_reset();
    n_cmp++; if (program_done !== 1'b0) begin n_err++; $display("FAIL mid_done_clr got %b want 0", program_done); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    do_cycle(32'h0003_0004, 8'h00, 0, 1, 0);
    n_cmp++; if (cpu_din !== 8'h00) begin n_err++; $display("FAIL mid_status got %h want 00", cpu_din); end
    $display("test_reset_mid: done");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        a = {$urandom_range(0, 16383), 2'b11, 13'h0, 3'($urandom_range(0, 7))};
      else
        a = {$urandom_range(0, 16383), 1'b0, 11'h0, 6'($urandom_range(0, 63))};
      do_cycle(a, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 2) == 0));
      n_cmp++; if (obs_rx_ready !== exp_rx_ready) begin n_err++; $display("FAIL rnd_rx_ready[%0d] got %b want %b", n, obs_rx_ready, exp_rx_ready); end
      n_cmp++; if (obs_ram_en !== exp_ram_en) begin n_err++; $display("FAIL rnd_ram_en[%0d] got %b want %b", n, obs_ram_en, exp_ram_en); end
      n_cmp++; if (tx_valid !== (tx_q.size() > 0)) begin n_err++; $display("FAIL rnd_tx_valid[%0d] got %b want %b", n, tx_valid, tx_q.size() > 0); end
      if (tx_q.size() > 0) begin
        n_cmp++; if (tx_data !== tx_q[0]) begin n_err++; $display("FAIL rnd_tx_data[%0d] got %h want %h", n, tx_data, tx_q[0]); end
      end
      n_cmp++; if (io_buffer_full !== (tx_q.size() >= TX_DEPTH - 1)) begin n_err++; $display("FAIL rnd_buf_full[%0d] got %b want %b", n, io_buffer_full, tx_q.size() >= TX_DEPTH - 1); end
      n_cmp++; if (program_done !== m_done) begin n_err++; $display("FAIL rnd_done[%0d] got %b want %b", n, program_done, m_done); end
      if (exp_chk) begin
        n_cmp++; if (cpu_din !== exp_din) begin n_err++; $display("FAIL rnd_din[%0d] got %h want %h", n, cpu_din, exp_din); end
      end
    end
    $display("test_random: 400 cycles, sink got %0d bytes", sink_q.size());
  endtask

  initial begin
    for (int i = 0; i < (1 << RAW); i++) ram_mem[i] = 8'h00;
    @(negedge clk_in);
    test_reset();
    test_ram_roundtrip();
    test_tx_stream();
    test_full_overflow();
    test_rx_read();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
